// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared encodings, widths and transition decode for the quadrature decoder
package quad_pkg;

    localparam int POS_W_DEF    = 16;
    localparam int PER_W_DEF    = 17;
    localparam int FILT_LEN_DEF = 4;

    // {a,b} phase encodings; forward order is 10 -> 11 -> 01 -> 00 -> 10
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_10 = 2'b10,
        PH_11 = 2'b11
    } quad_state_e;

    // Phase that follows s when the encoder turns forward
    function automatic logic [1:0] quad_fwd_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            PH_10:   n = PH_11;
            PH_11:   n = PH_01;
            PH_01:   n = PH_00;
            default: n = PH_10;
        endcase
        return n;
    endfunction

    // Returns {legal, fwd} for a change old_s -> new_s (old_s != new_s)
    function automatic logic [1:0] quad_step(input logic [1:0] old_s, input logic [1:0] new_s);
        logic fwd;
        logic rev;
        fwd = (new_s == quad_fwd_next(old_s));
        rev = (old_s == quad_fwd_next(new_s));
        return {fwd | rev, fwd};
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder inputs and decoded outputs of the quadrature decoder
interface quad_decoder_if import quad_pkg::*; #(
    parameter int POS_W = POS_W_DEF,
    parameter int PER_W = PER_W_DEF
) ();
    logic             a;
    logic             b;
    logic             clr;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             step;
    logic             err;
    logic [PER_W-1:0] period;
    logic             period_valid;

    modport master (
        output a, b, clr,
        input  pos, dir, step, err, period, period_valid
    );

    modport slave (
        input  a, b, clr,
        output pos, dir, step, err, period, period_valid
    );
endinterface

// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - 2-flop synchroniser plus stability filter for the {a,b} pair
module quad_input_filter import quad_pkg::*; #(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raw,
    output logic [1:0] state,
    output logic       upd,
    output logic       primed
);
    localparam int              CNT_W    = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN);

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_sync3;
    logic [1:0]       r_state;
    logic             r_upd;
    logic             r_primed;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_stable;
    logic w_accept;

    // A candidate only counts while it differs from the accepted state (or nothing is accepted yet)
    assign w_diff   = ~r_primed | (r_sync2 != r_state);
    assign w_stable = (r_sync2 == r_sync3);
    assign w_accept = w_diff & w_stable & (r_cnt == CNT_LAST);

    // Bring the asynchronous pins into the clock domain; r_sync3 detects synchronised changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_sync3 <= 2'b00;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Stability count and accepted state; the very first acceptance primes without a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_state  <= 2'b00;
            r_upd    <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (!w_stable) begin
                r_cnt <= CNT_ONE;
            end else if (w_accept) begin
                r_cnt    <= '0;
                r_state  <= r_sync2;
                r_upd    <= r_primed;
                r_primed <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign state  = r_state;
    assign upd    = r_upd;
    assign primed = r_primed;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decode into position, direction, step strobe, period and error
module quad_decoder import quad_pkg::*; #(
    parameter int POS_W    = POS_W_DEF,
    parameter int PER_W    = PER_W_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    quad_decoder_if.slave bus
);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);
    localparam logic [PER_W-1:0] CNT_MAX = '1;

    logic [1:0]       w_state;
    logic             w_upd;
    logic             w_primed;
    logic             w_legal;
    logic             w_fwd;
    logic             w_step;
    logic             w_bad;

    logic [1:0]       r_old;
    logic [POS_W-1:0] r_pos;
    logic             r_dir;
    logic             r_step;
    logic             r_err;
    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_period;
    logic             r_pv;
    logic             r_armed;

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    ({bus.a, bus.b}),
        .state  (w_state),
        .upd    (w_upd),
        .primed (w_primed)
    );

    // r_old still holds the previous filtered state during the cycle the filter strobes upd
    assign {w_legal, w_fwd} = quad_step(r_old, w_state);
    assign w_step = w_upd & w_primed & w_legal;
    assign w_bad  = w_upd & w_primed & ~w_legal;

    // Position, direction, step strobe and sticky error; clr overrides pos/err only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_old  <= 2'b00;
            r_pos  <= '0;
            r_dir  <= 1'b0;
            r_step <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_old  <= w_state;
            r_step <= w_step;
            if (w_step) begin
                r_dir <= w_fwd;
            end
            if (bus.clr) begin
                r_pos <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_step) begin
                    r_pos <= w_fwd ? (r_pos + POS_ONE) : (r_pos - POS_ONE);
                end
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Step-to-step period; an illegal jump disarms so the next step only restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_period <= '0;
            r_pv     <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_pv <= 1'b0;
            if (w_step) begin
                r_cnt   <= CNT_ONE;
                r_armed <= 1'b1;
                if (r_armed) begin
                    r_period <= r_cnt;
                    r_pv     <= 1'b1;
                end
            end else begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                if (w_bad) begin
                    r_armed <= 1'b0;
                end
            end
        end
    end

    assign bus.pos          = r_pos;
    assign bus.dir          = r_dir;
    assign bus.step         = r_step;
    assign bus.err          = r_err;
    assign bus.period       = r_period;
    assign bus.period_valid = r_pv;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder with a phase-order reference model
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int POS_W    = 16;
    localparam int PER_W    = 12;
    localparam int FILT_LEN = 4;
    localparam logic [PER_W-1:0] PMAX = '1;

    typedef struct {
        logic [POS_W-1:0] pos;
        logic             dir;
        logic             err;
        logic             pv;
        logic [PER_W-1:0] period;
    } exp_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    longint cyc  = 0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [1:0]       m_state;
    bit               m_primed;
    logic [POS_W-1:0] m_pos;
    logic             m_dir;
    logic             m_err;
    bit               m_armed;
    longint           m_last;

    quad_decoder_if #(.POS_W(POS_W), .PER_W(PER_W)) bus ();

    quad_decoder #(.POS_W(POS_W), .PER_W(PER_W), .FILT_LEN(FILT_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Position of a phase within the forward cycle 10,11,01,00
    function automatic int ph_idx(input logic [1:0] s);
        case (s)
            2'b10:   return 0;
            2'b11:   return 1;
            2'b01:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ph_at(input int i);
        case (i % 4)
            0:       return 2'b10;
            1:       return 2'b11;
            2:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Put v on the pins, update the model, then hold for 'hold' cycles (called just after a negedge)
    task automatic drive(input logic [1:0] v, input int hold);
        exp_t   e;
        int     d;
        longint dt;
        {bus.a, bus.b} = v;
        if (!m_primed) begin
            m_state  = v;
            m_primed = 1'b1;
        end else if (v != m_state) begin
            d = (ph_idx(v) - ph_idx(m_state) + 4) % 4;
            if (d == 2) begin
                m_err   = 1'b1;
                m_armed = 1'b0;
            end else begin
                m_pos    = (d == 1) ? m_pos + 1 : m_pos - 1;
                m_dir    = (d == 1);
                dt       = cyc - m_last;
                e.pv     = m_armed;
                e.period = (dt > longint'(PMAX)) ? PMAX : PER_W'(dt);
                e.pos    = m_pos;
                e.dir    = m_dir;
                e.err    = m_err;
                sb.push_back(e);
                m_armed = 1'b1;
                m_last  = cyc;
            end
            m_state = v;
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic step_by(input int d, input int hold);
        drive(ph_at(ph_idx(m_state) + d), hold);
    endtask

    // Flip one pin for len cycles without telling the model; too short to be accepted
    task automatic glitch(input int bit_sel, input int len);
        if (bit_sel == 0) bus.a = ~bus.a; else bus.b = ~bus.b;
        repeat (len) @(negedge clk);
        if (bit_sel == 0) bus.a = ~bus.a; else bus.b = ~bus.b;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        m_pos = '0;
        m_err = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_state(input string name);
        drain(name);
        check({name, "_pos"}, bus.pos, m_pos);
        check({name, "_dir"}, bus.dir, m_dir);
        check({name, "_err"}, bus.err, m_err);
    endtask

    task automatic check_zero(input string name);
        check({name, "_pos"},    bus.pos, 0);
        check({name, "_dir"},    bus.dir, 0);
        check({name, "_step"},   bus.step, 0);
        check({name, "_err"},    bus.err, 0);
        check({name, "_period"}, bus.period, 0);
        check({name, "_pv"},     bus.period_valid, 0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_primed = 1'b0;
        m_pos    = '0;
        m_dir    = 1'b0;
        m_err    = 1'b0;
        m_armed  = 1'b0;
        m_last   = 0;
    endtask

    // Monitor: every step strobe pops one expected event
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.step) begin
                if (sb.size() == 0) begin
                    check("unexpected_step", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("step_pos", bus.pos, e.pos);
                    check("step_dir", bus.dir, e.dir);
                    check("step_err", bus.err, e.err);
                    check("step_pv",  bus.period_valid, e.pv);
                    if (e.pv) check("step_period", bus.period, e.period);
                end
            end else if (bus.period_valid) begin
                check("pv_without_step", 1, 0);
            end
        end
    end

    initial begin
        int r;
        int hold;
        model_reset();
        bus.a   = 1'b1;
        bus.b   = 1'b0;
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Prime on 10, then eight forward steps of 40 clocks
        drive(2'b10, 20);
        for (int i = 0; i < 8; i++) step_by(1, 40);
        check_state("forward");
        check("forward_pos_8", bus.pos, 8);

        // Clear, then three reverse steps
        pulse_clr();
        check_state("clr1");
        for (int i = 0; i < 3; i++) step_by(3, 40);
        check_state("reverse");
        check("reverse_pos", bus.pos, 16'hFFFD);
        check("reverse_period", bus.period, 40);

        // 3-clock glitch is rejected, 5-clock pulse is two real steps
        glitch(0, 3);
        repeat (20) @(negedge clk);
        check_state("glitch3");
        step_by(1, 5);
        step_by(3, 40);
        check_state("pulse5");

        // Illegal jump, then a step that must not report a period, then clear
        step_by(2, 40);
        check_state("illegal");
        check("illegal_err", bus.err, 1);
        step_by(1, 40);
        step_by(1, 40);
        pulse_clr();
        check_state("clr2");

        // Stall longer than the period counter range
        step_by(1, (1 << PER_W) + 50);
        step_by(1, 40);
        check_state("stall");
        check("stall_period", bus.period, PMAX);

        // Random walk with occasional illegal jumps and glitches
        for (int i = 0; i < 60; i++) begin
            r    = $urandom_range(0, 9);
            hold = $urandom_range(8, 60);
            if (r == 0) step_by(2, 12);
            else if (r < 6) step_by(1, 12);
            else step_by(3, 12);
            if ($urandom_range(0, 3) == 0) begin
                glitch($urandom_range(0, 1), $urandom_range(1, 3));
                repeat (4) @(negedge clk);
            end
            repeat (hold) @(negedge clk);
        end
        check_state("random");

        // Reset while a transition is in the pipeline
        step_by(1, 3);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        drive(m_state, 20);
        check_state("reprime");
        step_by(3, 30);
        step_by(3, 30);
        check_state("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder for the A/B phase pair produced by the team's phase-sequence generator or an external incremental encoder. Both inputs are synchronised and glitch-filtered, then each legal Gray-code transition is decoded into a signed position count, a direction bit, a one-cycle step strobe and a step-period measurement. Illegal double-bit transitions raise a sticky error flag. The block sits between the encoder pins and the control/readout logic.

## Interface
- POS_W, 16, position counter width (two's complement, wraps)
- PER_W, 17, period counter width (saturating)
- FILT_LEN, 4, consecutive stable cycles required before a filtered input change is accepted (≥1)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a  in  1  phase A, asynchronous to clk
- b  in  1  phase B, asynchronous to clk
- clr  in  1  synchronous clear of pos and err
- pos  out  POS_W  signed position count
- dir  out  1  direction of last legal step (1 = forward)
- step  out  1  one-cycle strobe per legal transition
- err  out  1  sticky illegal-transition flag
- period  out  PER_W  clocks between the last two legal steps
- period_valid  out  1  one-cycle strobe when period is updated

## Operation
- State is the 2-bit value {a,b}. Forward sequence: 10 → 11 → 01 → 00 → 10. Reverse is the opposite order.
- Input path: 2-flop synchroniser per bit, then a 2-bit vector filter. The filtered state s_f changes only after the synchronised vector has held one value, different from s_f, for FILT_LEN consecutive cycles. Any change of the synchronised value restarts the stability count.
- After reset, s_f is unprimed. The first stable value loads s_f silently: no step, no err, no count change.
- On each s_f update (old→new):
  - Forward transition: pos += 1, dir = 1, step pulses.
  - Reverse transition: pos −= 1, dir = 0, step pulses.
  - Both bits changed (illegal): err = 1, pos/dir unchanged, no step, period measurement re-armed.
- pos wraps modulo 2^POS_W: 0 − 1 = all-ones, max + 1 = 0.
- Period counter cnt: reset value 0. Increments every cycle and saturates at 2^PER_W−1. On a step cycle, period ← cnt and cnt ← 1.
  - period_valid pulses with every step except the first after reset or after an illegal transition (re-arm). On those steps cnt ← 1 only.
  - A saturated period value means the encoder stalled.
- clr: pos ← 0 and err ← 0. If clr coincides with a step, clr wins for pos and err. step, dir and period behave normally.

## Timing
- Reset values: pos 0, dir 0, step 0, err 0, period 0, period_valid 0, cnt 0, s_f unprimed, filter count 0.
- Latency: an input change first sampled at edge k, then held stable, updates s_f at edge k+2+FILT_LEN. pos, dir, step, err, period and period_valid update at edge k+3+FILT_LEN.
- step and period_valid are high for exactly one cycle, in the same cycle.
- Minimum resolvable phase length: FILT_LEN+1 clocks. Shorter pulses are rejected as glitches.
- Reset asserted mid-operation returns everything to the reset values immediately. After release, the block re-primes.

## Structure
- Package quad_pkg holds:
  - the state encodings (PH_10, PH_11, PH_01, PH_00)
  - a function returning {legal, fwd} from an (old, new) state pair
  - default width constants
- Sub-module quad_input_filter (synchroniser + FILT_LEN stability filter + primed flag): in clk, rst_n, raw[1:0]; out state[1:0], upd, primed.
- Top level holds decode, pos, period and err logic.

## Test plan
- Forward drive, 40-clock phases 10,11,01,00 repeating, FILT_LEN=4, 8 steps → pos = 8, dir = 1, step every 40 clocks, period = 40 with period_valid from the 2nd step onward.
- Reverse drive 00,01,11,10 from pos = 0, 3 steps → pos = 0xFFFD, dir = 0, period = 40.
- 3-clock glitch on a during a stable phase → no step, pos unchanged. 5-clock pulse → accepted as a transition.
- Jump 10→01 → err = 1, pos unchanged, no step; next legal step gives no period_valid. clr → err = 0, pos = 0.
- No input activity for 2^17 clocks, then one step → period = 0x1FFFF.
- rst_n low mid-sequence → all outputs 0 within the same cycle; after release, first stable state produces no step.
